ball_motion: RTL and testbench

Parametrised ball motion engine for the pong datapath. It produces the ball's top-left pixel position each frame-rate tick, with independent X/Y speeds and reflection off the top and bottom walls. It resolves paddle hits and misses at the left and right edges and runs a serve/miss sequence. It drives the ball coordinate inputs of `graphics` and uses a clock-enable tick instead of a divided clock.

---
 rtl/ball_motion_if.sv | 17 +
 rtl/ball_motion.sv | 121 ++++++++++++
 tb/tb_ball_motion.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ball_motion_if.sv
// ball_motion_if: control, paddle and ball-state signals of the pong ball motion engine
// master drives enable/serve/serve_dir/speeds/paddles; slave (ball_motion) drives
// ball_x/ball_y/dir_x/dir_y/hit/miss_l/miss_r/active.
interface ball_motion_if #(parameter int W = 10, parameter int SPD_W = 4);
  logic enable, serve, serve_dir;
  logic [SPD_W-1:0] speed_x, speed_y;
  logic [W-1:0] paddle_l_y, paddle_r_y, ball_x, ball_y;
  logic dir_x, dir_y, hit, miss_l, miss_r, active;
  modport master (
    output enable, serve, serve_dir, speed_x, speed_y, paddle_l_y, paddle_r_y,
    input ball_x, ball_y, dir_x, dir_y, hit, miss_l, miss_r, active
  );
  modport slave (
    input enable, serve, serve_dir, speed_x, speed_y, paddle_l_y, paddle_r_y,
    output ball_x, ball_y, dir_x, dir_y, hit, miss_l, miss_r, active
  );
endinterface

// File: rtl/ball_motion.sv
// ball_motion: tick-driven ball position engine with wall bounce, paddle hit/miss and serve/miss sequencing
// clk50M/rst: clock and synchronous active-high reset; bus: ball_motion_if slave
// (control/speed/paddle inputs in, registered ball position, directions and event pulses out).
module ball_motion #(
  parameter int W = 10,
  parameter int SPD_W = 4,
  parameter int TICK_DIV = 19,
  parameter int X_MIN = 8,
  parameter int X_MAX = 624,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 472,
  parameter int X_INIT = 316,
  parameter int Y_INIT = 236,
  parameter int BALL_SIZE = 8,
  parameter int PAD_H = 64,
  parameter int MISS_TICKS = 32
) (
  input logic clk50M,
  input logic rst,
  ball_motion_if.slave bus
);
  localparam int W1 = W + 1;
  localparam int MC_W = $clog2(MISS_TICKS + 1);
  typedef enum logic [1:0] {IDLE, MOVING, MISS} state_t;
  state_t s, s_n;
  logic [TICK_DIV-1:0] cnt;
  logic [MC_W-1:0] mc, mc_n;
  logic [W-1:0] x, x_n, y, y_n;
  logic dx, dx_n, dy, dy_n, hit, hit_n, ml, ml_n, mr, mr_n;
  logic move, x_edge, y_edge, overlap;
  logic [W1-1:0] xe, ye, sx, sy, pad;
  // one extra bit keeps the bound checks free of wraparound
  assign xe = {1'b0, x};
  assign ye = {1'b0, y};
  assign sx = {{(W1-SPD_W){1'b0}}, bus.speed_x};
  assign sy = {{(W1-SPD_W){1'b0}}, bus.speed_y};
  assign pad = {1'b0, dx ? bus.paddle_r_y : bus.paddle_l_y};
  assign move = (&cnt) && bus.enable;
  assign x_edge = dx ? (xe + sx >= W1'(X_MAX)) : (xe <= W1'(X_MIN) + sx);
  assign y_edge = dy ? (ye + sy >= W1'(Y_MAX)) : (ye <= W1'(Y_MIN) + sy);
  assign overlap = (ye + W1'(BALL_SIZE) > pad) && (ye < pad + W1'(PAD_H));
  always_comb begin
    s_n = s;
    x_n = x;
    y_n = y;
    dx_n = dx;
    dy_n = dy;
    mc_n = mc;
    hit_n = 1'b0;
    ml_n = 1'b0;
    mr_n = 1'b0;
    if (s == IDLE && bus.serve) begin
      s_n = MOVING;
      dx_n = bus.serve_dir;
      dy_n = 1'b1;
    end
    if (s == MOVING && move) begin
      if (sy != '0) begin
        y_n = y_edge ? (dy ? W'(Y_MAX) : W'(Y_MIN)) : W'(dy ? ye + sy : ye - sy);
        dy_n = y_edge ? ~dy : dy;
      end
      if (sx != '0) begin
        x_n = x_edge ? (dx ? W'(X_MAX) : W'(X_MIN)) : W'(dx ? xe + sx : xe - sx);
        if (x_edge && overlap) begin
          dx_n = ~dx;
          hit_n = 1'b1;
        end
        if (x_edge && !overlap) begin
          ml_n = ~dx;
          mr_n = dx;
          s_n = MISS;
          mc_n = '0;
        end
      end
    end
    if (s == MISS && move) begin
      mc_n = mc + 1'b1;
      if (mc == MC_W'(MISS_TICKS - 1)) begin
        s_n = IDLE;
        x_n = W'(X_INIT);
        y_n = W'(Y_INIT);
        dx_n = 1'b1;
        dy_n = 1'b1;
        mc_n = '0;
      end
    end
  end
  always_ff @(posedge clk50M) begin
    if (rst) begin
      s <= IDLE;
      cnt <= '0;
      mc <= '0;
      x <= W'(X_INIT);
      y <= W'(Y_INIT);
      dx <= 1'b1;
      dy <= 1'b1;
      hit <= 1'b0;
      ml <= 1'b0;
      mr <= 1'b0;
    end else begin
      s <= s_n;
      cnt <= cnt + 1'b1;
      mc <= mc_n;
      x <= x_n;
      y <= y_n;
      dx <= dx_n;
      dy <= dy_n;
      hit <= hit_n;
      ml <= ml_n;
      mr <= mr_n;
    end
  end
  assign bus.ball_x = x;
  assign bus.ball_y = y;
  assign bus.dir_x = dx;
  assign bus.dir_y = dy;
  assign bus.hit = hit;
  assign bus.miss_l = ml;
  assign bus.miss_r = mr;
  assign bus.active = (s == MOVING);
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed self-checking bench for ball_motion with a 4-cycle tick
module tb_ball_motion;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] tcnt;
  int checks = 0;
  int errors = 0;
  ball_motion_if #(.W(10), .SPD_W(4)) bus ();
  ball_motion #(.TICK_DIV(2)) dut (.clk50M(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  // independent model of the free-running tick counter
  always @(posedge clk) tcnt <= rst ? 2'd0 : tcnt + 2'd1;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_moves(input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      g = 0;
      @(posedge clk);
      while (!(tcnt == 2'd3 && bus.enable) && g < 8) begin
        @(posedge clk);
        g++;
      end
      if (g >= 8) begin errors++; $display("FAIL wait_moves: no move edge within 8 cycles"); end
    end
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask
  task automatic do_serve(input logic d);
    bus.serve_dir = d;
    bus.serve = 1'b1;
    cyc(1);
    bus.serve = 1'b0;
  endtask
  task automatic test_reset();
    int pulses;
    bus.enable = 1'b0; bus.serve = 1'b0; bus.serve_dir = 1'b0;
    bus.speed_x = 4'd3; bus.speed_y = 4'd2; bus.paddle_l_y = '0; bus.paddle_r_y = '0;
    do_reset();
    checks++; if (bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236) begin errors++; $display("FAIL reset_pos got (%0d,%0d) want (316,236)", bus.ball_x, bus.ball_y); end
    checks++; if (bus.dir_x !== 1'b1 || bus.dir_y !== 1'b1 || bus.active !== 1'b0) begin errors++; $display("FAIL reset_state got dir=%b%b active=%b want 11/0", bus.dir_x, bus.dir_y, bus.active); end
    bus.enable = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (bus.hit || bus.miss_l || bus.miss_r || bus.active) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL idle_quiet got %0d busy cycles want 0", pulses); end
    checks++; if (bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236) begin errors++; $display("FAIL idle_pos got (%0d,%0d) want (316,236)", bus.ball_x, bus.ball_y); end
    bus.enable = 1'b0;
    do_serve(1'b1);
    checks++; if (bus.active !== 1'b1) begin errors++; $display("FAIL serve_disabled_active got %b want 1", bus.active); end
    cyc(12);
    checks++; if (bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236) begin errors++; $display("FAIL frozen_pos got (%0d,%0d) want (316,236)", bus.ball_x, bus.ball_y); end
  endtask
  task automatic test_serve();
    do_reset();
    bus.enable = 1'b1; bus.speed_x = 4'd3; bus.speed_y = 4'd2;
    do_serve(1'b1);
    checks++; if (bus.active !== 1'b1 || bus.ball_x !== 10'd316) begin errors++; $display("FAIL serve_latency got active=%b x=%0d want 1/316", bus.active, bus.ball_x); end
    wait_moves(5);
    checks++; if (bus.ball_x !== 10'd331 || bus.ball_y !== 10'd246) begin errors++; $display("FAIL serve_5moves got (%0d,%0d) want (331,246)", bus.ball_x, bus.ball_y); end
  endtask
  task automatic test_y_bounce();
    bus.speed_x = 4'd0; bus.speed_y = 4'd4;
    wait_moves(56);
    checks++; if (bus.ball_x !== 10'd331 || bus.ball_y !== 10'd470 || bus.dir_y !== 1'b1) begin errors++; $display("FAIL pre_bounce got (%0d,%0d) dy=%b want (331,470) 1", bus.ball_x, bus.ball_y, bus.dir_y); end
    wait_moves(1);
    checks++; if (bus.ball_y !== 10'd472 || bus.dir_y !== 1'b0) begin errors++; $display("FAIL bounce got y=%0d dy=%b want 472/0", bus.ball_y, bus.dir_y); end
    wait_moves(1);
    checks++; if (bus.ball_y !== 10'd468) begin errors++; $display("FAIL after_bounce got y=%0d want 468", bus.ball_y); end
  endtask
  task automatic test_left_hit();
    do_reset();
    bus.enable = 1'b1; bus.speed_x = 4'd0; bus.speed_y = 4'd8;
    do_serve(1'b0);
    checks++; if (bus.dir_x !== 1'b0 || bus.dir_y !== 1'b1) begin errors++; $display("FAIL serve_left_dir got %b%b want 01", bus.dir_x, bus.dir_y); end
    wait_moves(74);
    checks++; if (bus.ball_y !== 10'd120 || bus.dir_y !== 1'b0) begin errors++; $display("FAIL left_setup_y got y=%0d dy=%b want 120/0", bus.ball_y, bus.dir_y); end
    bus.speed_y = 4'd0; bus.speed_x = 4'd9;
    wait_moves(34);
    checks++; if (bus.ball_x !== 10'd10 || bus.ball_y !== 10'd120) begin errors++; $display("FAIL left_setup_x got (%0d,%0d) want (10,120)", bus.ball_x, bus.ball_y); end
    bus.speed_x = 4'd5; bus.paddle_l_y = 10'd100;
    wait_moves(1);
    checks++; if (bus.ball_x !== 10'd8 || bus.dir_x !== 1'b1 || bus.hit !== 1'b1 || bus.active !== 1'b1) begin errors++; $display("FAIL left_hit got x=%0d dx=%b hit=%b act=%b want 8/1/1/1", bus.ball_x, bus.dir_x, bus.hit, bus.active); end
    cyc(1);
    checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL hit_width got hit=%b want 0", bus.hit); end
  endtask
  task automatic test_right_miss();
    bus.speed_x = 4'd0; bus.speed_y = 4'd10; bus.paddle_r_y = 10'd0;
    wait_moves(42);
    checks++; if (bus.ball_y !== 10'd300 || bus.dir_y !== 1'b1) begin errors++; $display("FAIL right_setup_y got y=%0d dy=%b want 300/1", bus.ball_y, bus.dir_y); end
    bus.speed_y = 4'd0; bus.speed_x = 4'd15;
    wait_moves(41);
    checks++; if (bus.ball_x !== 10'd623 || bus.active !== 1'b1) begin errors++; $display("FAIL right_approach got x=%0d act=%b want 623/1", bus.ball_x, bus.active); end
    wait_moves(1);
    checks++; if (bus.ball_x !== 10'd624 || bus.miss_r !== 1'b1 || bus.miss_l !== 1'b0 || bus.hit !== 1'b0) begin errors++; $display("FAIL right_miss got x=%0d mr=%b ml=%b hit=%b want 624/1/0/0", bus.ball_x, bus.miss_r, bus.miss_l, bus.hit); end
    checks++; if (bus.active !== 1'b0 || bus.dir_x !== 1'b1) begin errors++; $display("FAIL miss_state got act=%b dx=%b want 0/1", bus.active, bus.dir_x); end
    cyc(1);
    checks++; if (bus.miss_r !== 1'b0) begin errors++; $display("FAIL miss_width got miss_r=%b want 0", bus.miss_r); end
    wait_moves(15);
    bus.enable = 1'b0;
    cyc(20);
    checks++; if (bus.ball_x !== 10'd624 || bus.active !== 1'b0) begin errors++; $display("FAIL miss_frozen got x=%0d act=%b want 624/0", bus.ball_x, bus.active); end
    bus.enable = 1'b1;
    wait_moves(16);
    checks++; if (bus.ball_x !== 10'd624 || bus.ball_y !== 10'd300) begin errors++; $display("FAIL miss_31ticks got (%0d,%0d) want (624,300)", bus.ball_x, bus.ball_y); end
    wait_moves(1);
    checks++; if (bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236 || bus.dir_x !== 1'b1 || bus.dir_y !== 1'b1 || bus.active !== 1'b0) begin errors++; $display("FAIL miss_return got (%0d,%0d) dir=%b%b act=%b want (316,236) 11 0", bus.ball_x, bus.ball_y, bus.dir_x, bus.dir_y, bus.active); end
  endtask
  task automatic test_corner_reset();
    bus.speed_x = 4'd0; bus.speed_y = 4'd12;
    do_serve(1'b1);
    wait_moves(1);
    bus.speed_x = 4'd11; bus.speed_y = 4'd8;
    wait_moves(27);
    checks++; if (bus.ball_x !== 10'd613 || bus.ball_y !== 10'd464) begin errors++; $display("FAIL corner_setup got (%0d,%0d) want (613,464)", bus.ball_x, bus.ball_y); end
    bus.paddle_r_y = 10'd420;
    wait_moves(1);
    checks++; if (bus.ball_x !== 10'd624 || bus.ball_y !== 10'd472 || bus.dir_x !== 1'b0 || bus.dir_y !== 1'b0) begin errors++; $display("FAIL corner_pos got (%0d,%0d) dir=%b%b want (624,472) 00", bus.ball_x, bus.ball_y, bus.dir_x, bus.dir_y); end
    checks++; if (bus.hit !== 1'b1 || bus.active !== 1'b1) begin errors++; $display("FAIL corner_hit got hit=%b act=%b want 1/1", bus.hit, bus.active); end
    bus.paddle_l_y = 10'd0; bus.speed_y = 4'd0; bus.speed_x = 4'd15;
    wait_moves(42);
    checks++; if (bus.ball_x !== 10'd8 || bus.miss_l !== 1'b1 || bus.active !== 1'b0) begin errors++; $display("FAIL left_miss got x=%0d ml=%b act=%b want 8/1/0", bus.ball_x, bus.miss_l, bus.active); end
    wait_moves(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    checks++; if (bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236 || bus.dir_x !== 1'b1 || bus.dir_y !== 1'b1) begin errors++; $display("FAIL midmiss_reset_pos got (%0d,%0d) dir=%b%b want (316,236) 11", bus.ball_x, bus.ball_y, bus.dir_x, bus.dir_y); end
    checks++; if (bus.active !== 1'b0 || bus.hit !== 1'b0 || bus.miss_l !== 1'b0 || bus.miss_r !== 1'b0) begin errors++; $display("FAIL midmiss_reset_out got act=%b hit=%b ml=%b mr=%b want 0", bus.active, bus.hit, bus.miss_l, bus.miss_r); end
    cyc(40);
    checks++; if (bus.ball_x !== 10'd316 || bus.active !== 1'b0) begin errors++; $display("FAIL post_reset_idle got x=%0d act=%b want 316/0", bus.ball_x, bus.active); end
  endtask
  initial begin
    test_reset();
    test_serve();
    test_y_bounce();
    test_left_hit();
    test_right_miss();
    test_corner_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
